// File: rtl/six_to_one_pipe_if.sv
// Stream bundle for six_to_one_pipe: input beat channel and output beat channel.
// The producer/consumer side uses master, the pipeline uses slave.
interface six_to_one_pipe_if #(
    parameter int LANES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [5*LANES-1:0]   in_a;
    logic [2*LANES-1:0]   in_b;
    logic                 in_inv;
    logic [LANES-1:0]     in_lane_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_x;

    modport master (
        output in_valid, in_a, in_b, in_inv, in_lane_en, out_ready,
        input  in_ready, out_valid, out_x
    );

    modport slave (
        input  in_valid, in_a, in_b, in_inv, in_lane_en, out_ready,
        output in_ready, out_valid, out_x
    );
endinterface

// File: rtl/six_to_one_pipe.sv
// Two-stage NAND/NOR gate-network pipeline, LANES independent lanes,
// valid/ready handshake with a saturating output-transfer counter.
module six_to_one_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    six_to_one_pipe_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] out_count
);

    function automatic logic [3:0] lane_s1(input logic [2:0] a);
        lane_s1[0] = ~(a[0] & a[1]);
        lane_s1[1] = ~(a[0] & a[2]);
        lane_s1[2] = ~(a[1] & a[2]);
        lane_s1[3] = ~(a[0] | a[1]);
    endfunction

    function automatic logic [2:0] lane_s2(input logic [1:0] b,
                                           input logic s13);
        lane_s2[0] = ~(b[0] & b[1]);
        lane_s2[1] = ~(b[0] & s13);
        lane_s2[2] = ~(b[1] | s13);
    endfunction

    function automatic logic [7:0] lane_x(input logic [1:0] ahi,
                                          input logic [3:0] s1,
                                          input logic [2:0] s2);
        lane_x[0] = ~(ahi[0] & ahi[1]);
        lane_x[1] = ~(ahi[0] & s2[2]);
        lane_x[2] = ~(ahi[1] | s2[2]);
        lane_x[3] = ~(s1[2] & s2[1]);
        lane_x[4] = ~(s1[2] & s2[0]);
        lane_x[5] = ~(s1[1] & s2[1]);
        lane_x[6] = ~(s1[1] & s2[0]);
        lane_x[7] = ~(s1[0] | s2[1]);
    endfunction

    logic                 v1_q, v1_d;
    logic                 v2_q, v2_d;
    logic [4*LANES-1:0]   s1_q, s1_d;
    logic [3*LANES-1:0]   s2_q, s2_d;
    logic [2*LANES-1:0]   ahi_q, ahi_d;
    logic                 inv_q, inv_d;
    logic [LANES-1:0]     en_q, en_d;
    logic [8*LANES-1:0]   x_q, x_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic adv1, adv2, in_rdy, acc, xfer;

    assign adv2   = ~v2_q | bus.out_ready;
    assign adv1   = ~v1_q | adv2;
    assign in_rdy = rst_n & adv1;
    assign acc    = bus.in_valid & in_rdy;
    assign xfer   = v2_q & bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = v2_q;
    assign bus.out_x     = x_q;
    assign out_count     = cnt_q;

    // Stage 1: capture first two gate levels of an accepted beat.
    always_comb begin
        v1_d  = v1_q;
        s1_d  = s1_q;
        s2_d  = s2_q;
        ahi_d = ahi_q;
        inv_d = inv_q;
        en_d  = en_q;
        if (adv1) begin
            v1_d = acc;
            if (acc) begin
                inv_d = bus.in_inv;
                en_d  = bus.in_lane_en;
                for (int l = 0; l < LANES; l++) begin
                    s1_d[4*l +: 4]  = lane_s1(bus.in_a[5*l +: 3]);
                    s2_d[3*l +: 3]  = lane_s2(bus.in_b[2*l +: 2],
                                              s1_d[4*l + 3]);
                    ahi_d[2*l +: 2] = bus.in_a[5*l + 3 +: 2];
                end
            end
        end
    end

    // Stage 2: final gate level, polarity and lane masking.
    always_comb begin
        v2_d = v2_q;
        x_d  = x_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                for (int l = 0; l < LANES; l++) begin
                    x_d[8*l +: 8] = en_q[l]
                        ? lane_x(ahi_q[2*l +: 2], s1_q[4*l +: 4],
                                 s2_q[3*l +: 3]) ^ {8{inv_q}}
                        : 8'h00;
                end
            end
        end
    end

    // Transfer counter: clear has priority, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (xfer && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    // State registers; reset discards any in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            ahi_q <= '0;
            inv_q <= 1'b0;
            en_q  <= '0;
            x_q   <= '0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            ahi_q <= ahi_d;
            inv_q <= inv_d;
            en_q  <= en_d;
            x_q   <= x_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_six_to_one_pipe.sv
// Self-checking bench for six_to_one_pipe: directed vectors, backpressure,
// counter saturation/clear, mid-run reset and randomized exhaustive lanes.
module tb_six_to_one_pipe;

    localparam int LANES = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             cnt_clr;
    logic [CNT_W-1:0] out_count;

    six_to_one_pipe_if #(.LANES(LANES)) bus ();

    six_to_one_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        int          c;
    } beat_t;

    beat_t       q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_xfer = 0;
    logic [3:0]  cnt_m = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_x = '0;
    logic [31:0] last_x = '0;
    logic        last_acc = 1'b0;
    logic        last_rdy = 1'b0;
    logic [31:0] seen0 = '0;
    logic [31:0] seen1 = '0;
    int          n_acc, d0, i, guard;
    logic [19:0] ra;
    logic [7:0]  rb;
    logic [6:0]  combo;

    function automatic logic [7:0] ref_lane(input logic [4:0] a,
                                            input logic [1:0] b,
                                            input logic inv,
                                            input logic en);
        logic p0, p1, p2, p3, q0, q1, q2;
        logic [7:0] x;
        p0 = !(a[0] && a[1]);
        p1 = !(a[0] && a[2]);
        p2 = !(a[1] && a[2]);
        p3 = !(a[0] || a[1]);
        q0 = !(b[0] && b[1]);
        q1 = !(b[0] && p3);
        q2 = !(b[1] || p3);
        x = {!(p0 || q1), !(p1 && q0), !(p1 && q1), !(p2 && q0),
             !(p2 && q1), !(a[4] || q2), !(a[3] && q2), !(a[3] && a[4])};
        if (!en) return 8'h00;
        return inv ? ~x : x;
    endfunction

    function automatic logic [31:0] ref_beat(input logic [19:0] a,
                                             input logic [7:0] b,
                                             input logic inv,
                                             input logic [3:0] en);
        logic [31:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++)
            r[8*l +: 8] = ref_lane(a[5*l +: 5], b[2*l +: 2], inv, en[l]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [19:0] a,
                         input logic [7:0] b, input logic inv,
                         input logic [3:0] en);
        bus.in_valid   = v;
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_inv     = inv;
        bus.in_lane_en = en;
    endtask

    // One clock cycle: sample mid-cycle, check against model, advance.
    task automatic step();
        logic oxfer;
        #3;
        last_acc = 1'b0;
        if (rst_n) begin
            chk("in_ready", bus.in_ready,
                (q.size() < 2) || bus.out_ready);
            chk("out_valid", bus.out_valid,
                (q.size() > 0) && (cyc - q[0].c >= 2));
            chk("out_count", out_count, cnt_m);
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_x", bus.out_x, prev_x);
            end
            last_rdy = bus.in_ready;
            oxfer = bus.out_valid && bus.out_ready;
            last_acc = bus.in_valid && bus.in_ready;
            if (oxfer) begin
                n_xfer++;
                last_x = bus.out_x;
                if (q.size() > 0) begin
                    chk("out_x", bus.out_x, q[0].x);
                    seen0 |= ~bus.out_x;
                    seen1 |= bus.out_x;
                    void'(q.pop_front());
                end
            end
            if (last_acc)
                q.push_back('{x: ref_beat(bus.in_a, bus.in_b, bus.in_inv,
                                          bus.in_lane_en), c: cyc});
            if (cnt_clr)
                cnt_m = '0;
            else if (oxfer && cnt_m != 4'hF)
                cnt_m = cnt_m + 4'd1;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_x = bus.out_x;
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic single(input string tag, input logic [4:0] a,
                          input logic [1:0] b, input logic inv,
                          input logic [3:0] en, input logic [7:0] expv);
        drive(1'b1, {4{a}}, {4{b}}, inv, en);
        step();
        drive(1'b0, '0, '0, 1'b0, '0);
        step();
        step();
        chk(tag, last_x[7:0], expv);
    endtask

    initial begin
        rst_n = 1'b0;
        cnt_clr = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_x", bus.out_x, 32'h0);
        chk("rst_count", out_count, 4'h0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("rdy_after_rst", bus.in_ready, 1'b1);

        bus.out_ready = 1'b1;
        single("v_zero", 5'b00000, 2'b00, 1'b0, 4'hF, 8'h07);
        single("v_zero_inv", 5'b00000, 2'b00, 1'b1, 4'hF, 8'hF8);
        single("v_ones", 5'b11111, 2'b11, 1'b0, 4'hF, 8'h7A);
        single("v_ones_inv", 5'b11111, 2'b11, 1'b1, 4'hF, 8'h85);
        single("v_disabled", 5'b11111, 2'b11, 1'b1, 4'hE, 8'h00);

        // backpressure: three beats against a stalled sink
        bus.out_ready = 1'b0;
        n_acc = 0;
        drive(1'b1, 20'h12345, 8'h1B, 1'b0, 4'hF);
        step();
        if (last_acc) n_acc++;
        drive(1'b1, 20'hABCDE, 8'hE4, 1'b1, 4'hF);
        step();
        if (last_acc) n_acc++;
        drive(1'b1, 20'h5A5A5, 8'h72, 1'b0, 4'h7);
        step();
        if (last_acc) n_acc++;
        chk("full_in_ready", last_rdy, 1'b0);
        chk("accepted_two", n_acc, 2);
        step();
        chk("still_full", last_rdy, 1'b0);
        bus.out_ready = 1'b1;
        d0 = n_xfer;
        step();
        drive(1'b0, '0, '0, 1'b0, '0);
        step();
        step();
        chk("drain_three", n_xfer - d0, 3);

        // counter saturation then clear coinciding with a transfer
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int k = 0; k < 22; k++) begin
            drive(1'b1, 20'($urandom), 8'($urandom), 1'($urandom), 4'hF);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        step();
        step();
        chk("count_sat", out_count, 4'hF);
        drive(1'b1, 20'h0F0F0, 8'h3C, 1'b1, 4'hF);
        step();
        step();
        cnt_clr = 1'b1;
        d0 = n_xfer;
        step();
        cnt_clr = 1'b0;
        chk("clr_had_xfer", n_xfer - d0, 1);
        chk("clr_wins", out_count, 4'h0);
        drive(1'b0, '0, '0, 1'b0, '0);
        for (int k = 0; k < 4; k++) step();

        // reset with two beats in flight
        bus.out_ready = 1'b0;
        drive(1'b1, 20'h11111, 8'h55, 1'b0, 4'hF);
        step();
        drive(1'b1, 20'h22222, 8'hAA, 1'b1, 4'hF);
        step();
        drive(1'b0, '0, '0, 1'b0, '0);
        chk("inflight_two", q.size(), 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_ready", bus.in_ready, 1'b0);
        chk("mid_rst_x", bus.out_x, 32'h0);
        chk("mid_rst_count", out_count, 4'h0);
        q.delete();
        cnt_m = '0;
        prev_stall = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("rdy_after_rst2", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        d0 = n_xfer;
        for (int k = 0; k < 4; k++) step();
        chk("no_stale", n_xfer - d0, 0);
        chk("count_after_rst", out_count, 4'h0);

        // random handshakes, every (A,B) combination on every lane
        i = 0;
        guard = 0;
        while (i < 128 && guard < 3000) begin
            ra = '0;
            rb = '0;
            for (int l = 0; l < LANES; l++) begin
                combo = 7'((i + 37 * l) % 128);
                ra[5*l +: 5] = combo[4:0];
                rb[2*l +: 2] = combo[6:5];
            end
            drive(($urandom % 4) != 0, ra, rb, 1'($urandom),
                  {($urandom % 8) != 0, ($urandom % 8) != 0,
                   ($urandom % 8) != 0, ($urandom % 8) != 0});
            bus.out_ready = ($urandom % 3) != 0;
            step();
            if (last_acc) i++;
            guard++;
        end
        chk("rand_all_sent", i, 128);
        drive(1'b0, '0, '0, 1'b0, '0);
        bus.out_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("rand_drained", q.size(), 0);
        for (int b = 0; b < 32; b++) begin
            chk($sformatf("seen0_%0d", b), seen0[b], 1'b1);
            chk($sformatf("seen1_%0d", b), seen1[b], 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
